// File: rtl/load_ctrl.sv
// Load controller: accepts lw/lh/lhu/lb/lbu requests, issues one word read, extracts the result.
// Optional bus-error timeout while waiting for m_rd_ack is enabled by defining LOAD_TIMEOUT_EN.
module load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  ld_op,
  input  logic        req_valid,
  input  logic [31:0] p_addr,
  input  logic        int_req,
  output logic        req_ready,
  output logic        m_rd_req,
  output logic [31:0] m_rd_addr,
  input  logic        m_rd_ack,
  input  logic [31:0] m_rd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        adel,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [2:0] OpLw  = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLb  = 3'd4;
  localparam logic [2:0] OpLbu = 3'd5;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e      state_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        kill_q;
  logic        req_ready_q, m_rd_req_q, rsp_valid_q, adel_q, busy_q;
  logic [31:0] m_rd_addr_q, rsp_data_q;
  logic        op_valid, misaligned, killed;
`ifdef LOAD_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        bus_err_q;
`endif

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    byte_v = w[7:0];
      2'd1:    byte_v = w[15:8];
      2'd2:    byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    case (op)
      OpLh:    extract = {{16{half_v[15]}}, half_v};
      OpLhu:   extract = {16'h0000, half_v};
      OpLb:    extract = {{24{byte_v[7]}}, byte_v};
      OpLbu:   extract = {24'h000000, byte_v};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    op_valid   = (ld_op >= OpLw) && (ld_op <= OpLbu);
    misaligned = ((ld_op == OpLw) && (p_addr[1:0] != 2'b00)) ||
                 (((ld_op == OpLh) || (ld_op == OpLhu)) && p_addr[0]);
    // A flush in the same cycle as the ack still kills the load.
    killed     = kill_q || int_req;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      kill_q      <= 1'b0;
      req_ready_q <= 1'b1;
      m_rd_req_q  <= 1'b0;
      m_rd_addr_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      adel_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      tmo_cnt_q   <= 32'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && op_valid && !int_req) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (misaligned) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              adel_q      <= 1'b1;
              rsp_data_q  <= 32'd0;
            end else begin
              state_q     <= StReq;
              op_q        <= ld_op;
              off_q       <= p_addr[1:0];
              kill_q      <= 1'b0;
              m_rd_req_q  <= 1'b1;
              m_rd_addr_q <= {p_addr[31:2], 2'b00};
`ifdef LOAD_TIMEOUT_EN
              tmo_cnt_q   <= 32'd0;
`endif
            end
          end
        end
        StReq: begin
          if (int_req) kill_q <= 1'b1;
          if (m_rd_ack) begin
            m_rd_req_q  <= 1'b0;
            m_rd_addr_q <= 32'd0;
            if (killed) begin
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= extract(op_q, off_q, m_rd_data);
            end
          end
`ifdef LOAD_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
            m_rd_req_q  <= 1'b0;
            m_rd_addr_q <= 32'd0;
            if (killed) begin
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 32'd0;
              bus_err_q   <= 1'b1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
`endif
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= 32'd0;
          adel_q      <= 1'b0;
          kill_q      <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
          bus_err_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  // A flush arriving during the response cycle drops the completion.
  assign rsp_valid = rsp_valid_q && !int_req;
  assign rsp_data  = rsp_valid ? rsp_data_q : 32'd0;
  assign adel      = adel_q && rsp_valid;
`ifdef LOAD_TIMEOUT_EN
  assign bus_err   = bus_err_q && rsp_valid;
`else
  assign bus_err   = 1'b0;
`endif
  assign req_ready = req_ready_q;
  assign m_rd_req  = m_rd_req_q;
  assign m_rd_addr = m_rd_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: directed scenarios plus randomized loads vs a reference model.
module tb_load_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  ld_op;
  logic        req_valid;
  logic [31:0] p_addr;
  logic        int_req;
  logic        req_ready;
  logic        m_rd_req;
  logic [31:0] m_rd_addr;
  logic        m_rd_ack;
  logic [31:0] m_rd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        adel;
  logic        bus_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ld_op     (ld_op),
    .req_valid (req_valid),
    .p_addr    (p_addr),
    .int_req   (int_req),
    .req_ready (req_ready),
    .m_rd_req  (m_rd_req),
    .m_rd_addr (m_rd_addr),
    .m_rd_ack  (m_rd_ack),
    .m_rd_data (m_rd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .adel      (adel),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  // Reference load result from shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned v;
    case (op)
      3'd1: return w;
      3'd2, 3'd3: begin
        v = (w >> (addr[1] ? 16 : 0)) & 32'hFFFF;
        if (op == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
        return v;
      end
      3'd4, 3'd5: begin
        v = (w >> (8 * addr[1:0])) & 32'hFF;
        if (op == 3'd4 && v >= 32'h80) v = v - 32'h100;
        return v;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'd1) return (addr % 4) != 0;
    if (op == 3'd2 || op == 3'd3) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ld_op = 3'd0; req_valid = 1'b0; p_addr = 32'd0; int_req = 1'b0;
    m_rd_ack = 1'b0; m_rd_data = 32'd0;
  endtask

  // Drives one load and monitors it until busy drops (bounded). waits<0: never ack.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int waits, input int kill_at,
                          output int busy_cycles, output bit got_rsp, output int rsp_cyc,
                          output logic [31:0] got_data, output logic got_adel,
                          output logic got_berr, output bit saw_mreq,
                          output logic [31:0] seen_addr);
    int cyc;
    int req_idx;
    busy_cycles = 0; got_rsp = 0; rsp_cyc = -1; got_data = 32'd0; got_adel = 1'b0;
    got_berr = 1'b0; saw_mreq = 0; seen_addr = 32'd0;
    ld_op = op; req_valid = 1'b1; p_addr = addr;
    tick;
    ld_op = 3'd0; req_valid = 1'b0;
    cyc = 1; req_idx = 0;
    while (busy && cyc < 200) begin
      busy_cycles++;
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = cyc; got_data = rsp_data; got_adel = adel; got_berr = bus_err;
      end
      if (m_rd_req) begin
        saw_mreq = 1; seen_addr = m_rd_addr;
        m_rd_ack = (req_idx == waits); m_rd_data = data;
        int_req = (req_idx == kill_at);
        req_idx++;
      end else begin
        m_rd_ack = 1'b0; int_req = 1'b0;
      end
      tick;
      cyc++;
    end
    m_rd_ack = 1'b0; int_req = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs; resetn = 1'b0;
    tick; tick;
    resetn = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if ({busy, m_rd_req, rsp_valid, adel, bus_err} !== 5'b0) begin
      errors++; $display("FAIL reset_outs got=%b exp=00000", {busy, m_rd_req, rsp_valid, adel, bus_err});
    end
    checks++; if (m_rd_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", m_rd_addr); end
  endtask

  task automatic test_lb;
    int bc, rc; bit gr, sm; logic [31:0] gd, sa; logic ga, gb;
    run_load(3'd4, 32'h103, 32'h80AABBCC, 0, -1, bc, gr, rc, gd, ga, gb, sm, sa);
    checks++; if (sa !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=00000100", sa); end
    checks++; if (gd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", gd); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL lb_latency got=%0d exp=2", rc); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_lhu;
    int bc, rc; bit gr, sm; logic [31:0] gd, sa; logic ga, gb;
    run_load(3'd3, 32'h202, 32'hF00D1234, 3, -1, bc, gr, rc, gd, ga, gb, sm, sa);
    checks++; if (gd !== 32'h0000F00D) begin errors++; $display("FAIL lhu_data got=%h exp=0000f00d", gd); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL lhu_busy got=%0d exp=5", bc); end
  endtask

  task automatic test_misaligned;
    int bc, rc; bit gr, sm; logic [31:0] gd, sa; logic ga, gb;
    run_load(3'd1, 32'h301, 32'hDEADBEEF, 0, -1, bc, gr, rc, gd, ga, gb, sm, sa);
    checks++; if (sm !== 1'b0) begin errors++; $display("FAIL mis_mreq got=%b exp=0", sm); end
    checks++; if (rc !== 1 || ga !== 1'b1 || gd !== 32'd0) begin
      errors++; $display("FAIL mis_rsp got cyc=%0d adel=%b data=%h exp cyc=1 adel=1 data=0", rc, ga, gd);
    end
  endtask

  task automatic test_flush;
    int bc, rc; bit gr, sm; logic [31:0] gd, sa; logic ga, gb;
    run_load(3'd1, 32'h400, 32'h12345678, 3, 1, bc, gr, rc, gd, ga, gb, sm, sa);
    checks++; if (gr !== 1'b0) begin errors++; $display("FAIL flush_rsp got=%b exp=0", gr); end
    checks++; if (bc !== 4 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got busy=%0d ready=%b exp busy=4 ready=1", bc, req_ready);
    end
  endtask

  task automatic test_resp_int;
    // Misaligned load reaches RESP next cycle; flush it there.
    ld_op = 3'd2; req_valid = 1'b1; p_addr = 32'h501;
    tick;
    ld_op = 3'd0; req_valid = 1'b0; int_req = 1'b1;
    #1;
    checks++; if ({rsp_valid, adel} !== 2'b00) begin
      errors++; $display("FAIL resp_int got=%b exp=00", {rsp_valid, adel});
    end
    tick;
    int_req = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_int_idle got busy=%b ready=%b exp 0 1", busy, req_ready);
    end
  endtask

  task automatic test_no_accept;
    for (int i = 0; i < 3; i++) begin
      ld_op = (i == 2) ? 3'd1 : 3'(6 + i); req_valid = 1'b1; p_addr = 32'h600; int_req = (i == 2);
      tick;
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL no_accept%0d got busy=%b ready=%b exp 0 1", i, busy, req_ready);
      end
    end
    idle_inputs;
  endtask

  task automatic test_reset_mid_req;
    ld_op = 3'd1; req_valid = 1'b1; p_addr = 32'h700;
    tick;
    idle_inputs; resetn = 1'b0;
    tick;
    resetn = 1'b1;
    checks++; if ({m_rd_req, rsp_valid, busy, req_ready} !== 4'b0001) begin
      errors++; $display("FAIL rst_req got=%b exp=0001", {m_rd_req, rsp_valid, busy, req_ready});
    end
    m_rd_ack = 1'b1; m_rd_data = 32'hAAAA5555;
    tick;
    m_rd_ack = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL stray_ack got=%b exp=00", {rsp_valid, busy});
    end
  endtask

  task automatic test_timeout;
    int bc, rc; bit gr, sm; logic [31:0] gd, sa; logic ga, gb;
    run_load(3'd1, 32'h800, 32'h0, -1, -1, bc, gr, rc, gd, ga, gb, sm, sa);
`ifdef LOAD_TIMEOUT_EN
    checks++; if (rc !== 17 || gb !== 1'b1 || gd !== 32'd0) begin
      errors++; $display("FAIL timeout got cyc=%0d berr=%b data=%h exp 17 1 0", rc, gb, gd);
    end
`else
    checks++; if (bc < 100 || gr !== 1'b0 || m_rd_req !== 1'b1) begin
      errors++; $display("FAIL no_timeout got busy=%0d rsp=%b mreq=%b exp >=100 0 1", bc, gr, m_rd_req);
    end
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
`endif
  endtask

  task automatic test_random;
    int bc, rc, w; bit gr, sm, mis; logic [31:0] gd, sa, a, d; logic ga, gb; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 5)); a = $urandom; d = $urandom; w = $urandom_range(0, 3);
      mis = ref_misaligned(op, a);
      run_load(op, a, d, w, -1, bc, gr, rc, gd, ga, gb, sm, sa);
      checks++;
      if (mis) begin
        if (rc !== 1 || ga !== 1'b1 || gd !== 32'd0 || sm !== 1'b0) begin
          errors++; $display("FAIL rand%0d_mis op=%0d a=%h got cyc=%0d adel=%b data=%h mreq=%b exp 1 1 0 0",
                             i, op, a, rc, ga, gd, sm);
        end
      end else if (rc !== w + 2 || ga !== 1'b0 || gb !== 1'b0 || gd !== ref_load(op, a, d)
                   || sa !== (a & 32'hFFFFFFFC)) begin
        errors++; $display("FAIL rand%0d op=%0d a=%h got cyc=%0d data=%h maddr=%h exp cyc=%0d data=%h maddr=%h",
                           i, op, a, rc, gd, sa, w + 2, ref_load(op, a, d), a & 32'hFFFFFFFC);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lb;
    test_lhu;
    test_misaligned;
    test_flush;
    test_resp_int;
    test_no_accept;
    test_reset_mid_req;
    test_timeout;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
